// File: rtl/ahb_slave_mem_arb_if.sv
// Signal bundle between two requesters, the arbiter and a synchronous memory.
// The slave modport is the arbiter; master is the requester/memory environment.
interface ahb_slave_mem_arb_if #(
  parameter int ADDR_BITS = 24,
  parameter int DATA_BITS = 32
);
  logic                   req0, wr0, lock0;
  logic [ADDR_BITS-1:0]   addr0;
  logic [DATA_BITS-1:0]   wdata0;
  logic [DATA_BITS/8-1:0] bsel0;
  logic                   req1, wr1, lock1;
  logic [ADDR_BITS-1:0]   addr1;
  logic [DATA_BITS-1:0]   wdata1;
  logic [DATA_BITS/8-1:0] bsel1;

  logic                   gnt0, rvalid0;
  logic [DATA_BITS-1:0]   rdata0;
  logic                   gnt1, rvalid1;
  logic [DATA_BITS-1:0]   rdata1;

  logic                   WR;
  logic [ADDR_BITS-1:0]   ADDR_WR;
  logic [DATA_BITS-1:0]   DIN;
  logic [DATA_BITS/8-1:0] BSEL;
  logic                   RD;
  logic [ADDR_BITS-1:0]   ADDR_RD;
  logic [DATA_BITS-1:0]   DOUT;

  modport slave (
    input  req0, wr0, lock0, addr0, wdata0, bsel0,
    input  req1, wr1, lock1, addr1, wdata1, bsel1,
    input  DOUT,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
    output WR, ADDR_WR, DIN, BSEL, RD, ADDR_RD
  );

  modport master (
    output req0, wr0, lock0, addr0, wdata0, bsel0,
    output req1, wr1, lock1, addr1, wdata1, bsel1,
    output DOUT,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
    input  WR, ADDR_WR, DIN, BSEL, RD, ADDR_RD
  );
endinterface

// File: rtl/ahb_slave_mem_arb.sv
// Two-port round-robin arbiter with bounded lock in front of a single-port
// synchronous memory; grants complete in the request cycle, reads return next cycle.
module ahb_slave_mem_arb #(
  parameter int ADDR_BITS = 24,
  parameter int DATA_BITS = 32,
  parameter int MAX_LOCK  = 16
) (
  input  logic               clk,
  input  logic               reset,
  ahb_slave_mem_arb_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;
  localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);

  logic [1:0] state_q, state_d;
  logic       last_p_q, last_p_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_tag_q, rd_tag_d;

  logic [1:0] req_v, lock_v, gnt_v;
  logic       owned, owner, locked;
  logic       gnt_any, gnt_p, wr_go, rd_go;
  logic                   sel_wr;
  logic [ADDR_BITS-1:0]   sel_addr;
  logic [DATA_BITS-1:0]   sel_wdata;
  logic [DATA_BITS/8-1:0] sel_bsel;

  // Requests are masked while reset is low so nothing reaches the memory.
  assign req_v  = {bus.req1, bus.req0} & {2{reset}};
  assign lock_v = {bus.lock1, bus.lock0};
  assign owned  = (state_q != IDLE);
  assign owner  = (state_q == OWN1);
  assign locked = owned && lock_v[owner] && (lock_cnt_q < LOCK_MAX);

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    gnt_v = 2'b00;
    if (locked)
      gnt_v[owner] = req_v[owner];
    else if (req_v == 2'b11)
      gnt_v[~last_p_q] = 1'b1;
    else
      gnt_v = req_v;
  end

  assign gnt_any   = |gnt_v;
  assign gnt_p     = gnt_v[1];
  assign sel_wr    = gnt_p ? bus.wr1    : bus.wr0;
  assign sel_addr  = gnt_p ? bus.addr1  : bus.addr0;
  assign sel_wdata = gnt_p ? bus.wdata1 : bus.wdata0;
  assign sel_bsel  = gnt_p ? bus.bsel1  : bus.bsel0;
  assign wr_go     = gnt_any &  sel_wr;
  assign rd_go     = gnt_any & ~sel_wr;

  assign bus.gnt0    = gnt_v[0];
  assign bus.gnt1    = gnt_v[1];
  assign bus.WR      = wr_go;
  assign bus.RD      = rd_go;
  assign bus.ADDR_WR = wr_go ? sel_addr  : '0;
  assign bus.DIN     = wr_go ? sel_wdata : '0;
  assign bus.BSEL    = wr_go ? sel_bsel  : '0;
  assign bus.ADDR_RD = rd_go ? sel_addr  : '0;

  // Lock count runs only while the same owner keeps lock asserted; any handover restarts it.
  always_comb begin
    state_d    = state_q;
    last_p_d   = last_p_q;
    lock_cnt_d = lock_cnt_q;
    rd_pend_d  = rd_go;
    rd_tag_d   = gnt_p;
    if (gnt_any) begin
      state_d  = gnt_p ? OWN1 : OWN0;
      last_p_d = gnt_p;
      if (owned && (owner == gnt_p) && lock_v[gnt_p]) begin
        if (lock_cnt_q < LOCK_MAX)
          lock_cnt_d = lock_cnt_q + 8'd1;
      end else begin
        lock_cnt_d = '0;
      end
    end else if (!(owned && lock_v[owner])) begin
      state_d    = IDLE;
      lock_cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_p_q   <= 1'b1;
      lock_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_tag_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_p_q   <= last_p_d;
      lock_cnt_q <= lock_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_tag_q   <= rd_tag_d;
    end
  end

  // Memory returns DOUT one cycle after RD; the tag steers it to the issuing port.
  assign bus.rvalid0 = rd_pend_q & ~rd_tag_q;
  assign bus.rvalid1 = rd_pend_q &  rd_tag_q;
  assign bus.rdata0  = (rd_pend_q & ~rd_tag_q) ? bus.DOUT : '0;
  assign bus.rdata1  = (rd_pend_q &  rd_tag_q) ? bus.DOUT : '0;
endmodule

// File: tb/tb_ahb_slave_mem_arb.sv
// Scoreboard bench for ahb_slave_mem_arb: stimulus pushes expected grants and
// read returns, a negedge monitor pops and compares them against the DUT.
module tb_ahb_slave_mem_arb;
  localparam int AB = 24;
  localparam int DB = 32;
  localparam int ML = 4;

  typedef struct {
    int            port;
    logic          wr;
    logic [AB-1:0] addr;
    logic [DB-1:0] data;
    logic [DB/8-1:0] bsel;
  } gnt_t;

  typedef struct {
    int            port;
    logic [DB-1:0] data;
  } rd_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  gnt_t gq[$];
  rd_t  rq[$];

  always #5 clk = ~clk;

  ahb_slave_mem_arb_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

  ahb_slave_mem_arb #(.ADDR_BITS(AB), .DATA_BITS(DB), .MAX_LOCK(ML)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model: registered read data, garbage when no read was issued.
  function automatic logic [DB-1:0] dout_of(input logic [AB-1:0] a);
    case (a)
      24'h30:  dout_of = 32'h0000_000A;
      24'h31:  dout_of = 32'h0000_000B;
      default: dout_of = {8'hD0, a};
    endcase
  endfunction

  always @(posedge clk)
    bus.DOUT <= bus.RD ? dout_of(bus.ADDR_RD) : 32'h5A5A_5A5A;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_p0(input logic r, input logic w, input logic l, input logic [AB-1:0] a,
                        input logic [DB-1:0] d, input logic [DB/8-1:0] b);
    bus.req0 = r; bus.wr0 = w; bus.lock0 = l; bus.addr0 = a; bus.wdata0 = d; bus.bsel0 = b;
  endtask

  task automatic set_p1(input logic r, input logic w, input logic l, input logic [AB-1:0] a,
                        input logic [DB-1:0] d, input logic [DB/8-1:0] b);
    bus.req1 = r; bus.wr1 = w; bus.lock1 = l; bus.addr1 = a; bus.wdata1 = d; bus.bsel1 = b;
  endtask

  task automatic exp_gnt(input int port, input logic wr, input logic [AB-1:0] addr,
                         input logic [DB-1:0] data, input logic [DB/8-1:0] bsel);
    gnt_t e;
    e.port = port; e.wr = wr; e.addr = addr; e.data = data; e.bsel = bsel;
    gq.push_back(e);
  endtask

  task automatic exp_rd(input int port, input logic [DB-1:0] data);
    rd_t r;
    r.port = port; r.data = data;
    rq.push_back(r);
  endtask

  always @(negedge clk) begin : monitor
    gnt_t e;
    rd_t  r;
    if (bus.gnt0 || bus.gnt1) begin
      if (gq.size() == 0) begin
        check("unexpected_gnt", 64'({bus.gnt1, bus.gnt0}), 64'd0);
      end else begin
        e = gq.pop_front();
        check("gnt_port", 64'({bus.gnt1, bus.gnt0}), (e.port == 1) ? 64'd2 : 64'd1);
        check("wr_rd", 64'({bus.WR, bus.RD}), e.wr ? 64'd2 : 64'd1);
        if (e.wr) begin
          check("addr_wr", 64'(bus.ADDR_WR), 64'(e.addr));
          check("din", 64'(bus.DIN), 64'(e.data));
          check("bsel", 64'(bus.BSEL), 64'(e.bsel));
          check("addr_rd_zero", 64'(bus.ADDR_RD), 64'd0);
        end else begin
          check("addr_rd", 64'(bus.ADDR_RD), 64'(e.addr));
          check("wr_side_zero", 64'({bus.ADDR_WR, bus.DIN, bus.BSEL}), 64'd0);
        end
      end
    end else begin
      check("idle_outputs", 64'({bus.WR, bus.RD, bus.ADDR_WR, bus.ADDR_RD}), 64'd0);
      check("idle_data", 64'({bus.DIN, bus.BSEL}), 64'd0);
    end

    if (bus.rvalid0 || bus.rvalid1) begin
      if (rq.size() == 0) begin
        check("unexpected_rvalid", 64'({bus.rvalid1, bus.rvalid0}), 64'd0);
      end else begin
        r = rq.pop_front();
        check("rvalid_port", 64'({bus.rvalid1, bus.rvalid0}), (r.port == 1) ? 64'd2 : 64'd1);
        check("rdata", 64'((r.port == 1) ? bus.rdata1 : bus.rdata0), 64'(r.data));
        check("rdata_other_zero", 64'((r.port == 1) ? bus.rdata0 : bus.rdata1), 64'd0);
      end
    end else begin
      check("rdata_idle_zero", {bus.rdata1, bus.rdata0}, 64'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with both ports requesting: nothing may leak to the memory or requesters.
    set_p0(1'b1, 1'b0, 1'b0, 24'h10, 32'h0, 4'h0);
    set_p1(1'b1, 1'b1, 1'b0, 24'h20, 32'hFFFF_FFFF, 4'hF);
    @(negedge clk);
    check("rst_gnt", 64'({bus.gnt1, bus.gnt0}), 64'd0);
    check("rst_wr_rd", 64'({bus.WR, bus.RD}), 64'd0);
    check("rst_addr", 64'({bus.ADDR_WR, bus.ADDR_RD}), 64'd0);
    check("rst_din_bsel", 64'({bus.DIN, bus.BSEL}), 64'd0);
    check("rst_rvalid", 64'({bus.rvalid1, bus.rvalid0}), 64'd0);
    check("rst_rdata", {bus.rdata1, bus.rdata0}, 64'd0);
    #1;
    set_p0(1'b0, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
    set_p1(1'b0, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
    @(negedge clk);
    #1 reset = 1'b1;
    step();

    // Tie: both read every cycle, port 0 first, strict alternation.
    set_p0(1'b1, 1'b0, 1'b0, 24'h10, 32'h0, 4'h0);
    set_p1(1'b1, 1'b0, 1'b0, 24'h20, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        exp_gnt(0, 1'b0, 24'h10, 32'h0, 4'h0);
        exp_rd(0, 32'hD000_0010);
      end else begin
        exp_gnt(1, 1'b0, 24'h20, 32'h0, 4'h0);
        exp_rd(1, 32'hD000_0020);
      end
      step();
    end

    // Full-word write from port 0, then a partial-byte write from port 1.
    set_p1(1'b0, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
    set_p0(1'b1, 1'b1, 1'b0, 24'h5, 32'hDEAD_BEEF, 4'hF);
    exp_gnt(0, 1'b1, 24'h5, 32'hDEAD_BEEF, 4'hF);
    step();
    set_p0(1'b0, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
    set_p1(1'b1, 1'b1, 1'b0, 24'h6, 32'h1234_5678, 4'h3);
    exp_gnt(1, 1'b1, 24'h6, 32'h1234_5678, 4'h3);
    step();

    // Routing: port 1 read then immediate port 0 read.
    set_p1(1'b1, 1'b0, 1'b0, 24'h30, 32'h0, 4'h0);
    exp_gnt(1, 1'b0, 24'h30, 32'h0, 4'h0);
    exp_rd(1, 32'h0000_000A);
    step();
    set_p1(1'b0, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
    set_p0(1'b1, 1'b0, 1'b0, 24'h31, 32'h0, 4'h0);
    exp_gnt(0, 1'b0, 24'h31, 32'h0, 4'h0);
    exp_rd(0, 32'h0000_000B);
    step();
    set_p0(1'b0, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
    step();

    // Lock: port 1 acquires alone, then holds off port 0 for MAX_LOCK grants.
    set_p1(1'b1, 1'b1, 1'b1, 24'h40, 32'h11, 4'hF);
    exp_gnt(1, 1'b1, 24'h40, 32'h11, 4'hF);
    step();
    set_p0(1'b1, 1'b1, 1'b0, 24'h41, 32'h22, 4'hF);
    for (int i = 0; i < 6; i++) begin
      if (i == 4) exp_gnt(0, 1'b1, 24'h41, 32'h22, 4'hF);
      else        exp_gnt(1, 1'b1, 24'h40, 32'h11, 4'hF);
      step();
    end

    // Locked owner idle: port 0 must wait; releasing the lock lets it in.
    set_p1(1'b0, 1'b0, 1'b1, 24'h0, 32'h0, 4'h0);
    step();
    set_p1(1'b0, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
    exp_gnt(0, 1'b1, 24'h41, 32'h22, 4'hF);
    step();

    // Reset mid-read: the granted read must never return data.
    set_p0(1'b1, 1'b0, 1'b0, 24'h50, 32'h0, 4'h0);
    exp_gnt(0, 1'b0, 24'h50, 32'h0, 4'h0);
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_gnt", 64'({bus.gnt1, bus.gnt0}), 64'd0);
    check("midrst_wr_rd", 64'({bus.WR, bus.RD}), 64'd0);
    check("midrst_addr", 64'({bus.ADDR_WR, bus.ADDR_RD}), 64'd0);
    check("midrst_rvalid", 64'({bus.rvalid1, bus.rvalid0}), 64'd0);
    #1;
    set_p0(1'b0, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
    reset = 1'b1;
    step();

    // After reset the priority pointer favours port 0 again.
    set_p0(1'b1, 1'b0, 1'b0, 24'h10, 32'h0, 4'h0);
    set_p1(1'b1, 1'b0, 1'b0, 24'h20, 32'h0, 4'h0);
    exp_gnt(0, 1'b0, 24'h10, 32'h0, 4'h0);
    exp_rd(0, 32'hD000_0010);
    step();
    set_p0(1'b0, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
    set_p1(1'b0, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
    step();
    step();

    check("gnt_queue_drained", 64'(gq.size()), 64'd0);
    check("rd_queue_drained", 64'(rq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_slave_mem_arb.md
AHB_SLAVE_MEM_ARB -- requirements
Module: ahb_slave_mem_arb

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 24, memory word-address width.
REQ-002 SHALL have parameter DATA_BITS, default 32, memory data width (multiple of 32).
REQ-003 SHALL have parameter MAX_LOCK, default 16, maximum consecutive locked transfers granted to one port (range 1..255).
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-006 SHALL have per requester p (p = 0, 1) the inputs reqP (1, transfer request), wrP (1, 1 = write, 0 = read), lockP (1, keep ownership), addrP (ADDR_BITS, word address), wdataP (DATA_BITS, write data), bselP (DATA_BITS/8, byte selects).
REQ-007 SHALL have per requester p the outputs gntP (1, transfer accepted this cycle), rvalidP (1, read data valid), rdataP (DATA_BITS, read data).
REQ-008 SHALL have memory-side outputs WR (1), ADDR_WR (ADDR_BITS), DIN (DATA_BITS), BSEL (DATA_BITS/8), RD (1), ADDR_RD (ADDR_BITS).
REQ-009 SHALL have memory-side input DOUT (DATA_BITS), valid exactly one cycle after RD.

Function
REQ-010 SHALL implement states IDLE, OWN0, OWN1 and a priority pointer last_p (port granted most recently).
REQ-011 In IDLE, or in OWNp with lockP = 0, the arbiter SHALL pick among active reqs round-robin: the port other than last_p wins when both request.
REQ-012 In OWNp with lockP = 1 and lock_cnt < MAX_LOCK, only port p SHALL be granted; the other port's request waits.
REQ-013 gntP SHALL be combinational in the same cycle as reqP; at most one gnt high per cycle; a granted transfer completes in that cycle.
REQ-014 On a granted write: WR = 1, ADDR_WR = addrP, DIN = wdataP, BSEL = bselP, same cycle; RD = 0.
REQ-015 On a granted read: RD = 1, ADDR_RD = addrP, same cycle; WR = 0.
REQ-016 No grant: WR = 0, RD = 0; address/data outputs SHALL be driven to 0.
REQ-017 A registered owner tag SHALL record the port of each granted read; next cycle rvalid(tag) = 1 and rdata(tag) = DOUT, the other rvalid = 0; rdata of a non-valid port = 0.
REQ-018 Back-to-back reads (one per cycle, either port) SHALL be supported at full throughput with correct routing of each DOUT.
REQ-019 After a grant to p, state SHALL become OWNp and last_p = p; with no grant, state SHALL become IDLE if lockP = 0, else remain OWNp.
REQ-020 lock_cnt (8 bits) SHALL increment on each grant to the owner while its lock = 1, saturate at MAX_LOCK, and clear on ownership change or lock deassertion.
REQ-021 When lock_cnt = MAX_LOCK and the other port requests, the other port SHALL be granted (lock overridden) and lock_cnt cleared; with no competing request, the owner keeps being granted.
REQ-022 A request withdrawn before grant SHALL be dropped without side effects; requesters SHALL hold inputs stable until gnt.

Reset
REQ-023 With reset = 0: state = IDLE, last_p = 1 (port 0 wins the first tie), lock_cnt = 0, owner tag cleared, all gnt, rvalid, WR, RD = 0, all data/address outputs = 0.
REQ-024 A read granted in the cycle reset asserts SHALL NOT produce rvalid after reset release.
REQ-025 Reset release SHALL take effect at the first rising clk edge after reset goes high; no grant in that edge's preceding cycle is required.

Verification
REQ-026 Tie: after reset, req0 = req1 = 1 reads, addr0 = 0x10, addr1 = 0x20 for 4 cycles -> gnt sequence 0,1,0,1; ADDR_RD 0x10,0x20,0x10,0x20; rvalid alternates one cycle later with matching DOUT.
REQ-027 Write: req0 = 1, wr0 = 1, addr0 = 0x5, wdata0 = 0xDEADBEEF, bsel0 = 0xF -> same cycle gnt0 = 1, WR = 1, ADDR_WR = 0x5, DIN = 0xDEADBEEF, BSEL = 0xF.
REQ-028 Lock: MAX_LOCK = 4, port 1 holds req1 = lock1 = 1, port 0 requests -> gnt1 for 4 cycles, then gnt0 one cycle, then gnt1 resumes.
REQ-029 Routing: read by port 1 then immediate read by port 0 with DOUT = 0xA then 0xB -> rvalid1/rdata1 = 0xA, next cycle rvalid0/rdata0 = 0xB.
REQ-030 Reset mid-read: grant read, assert reset before next edge -> no rvalid; all outputs 0 while reset = 0.
